// File: rtl/ibr128_pkg.sv
// ---------------------------------------------------------------------------
// ibr128_pkg
// Shared types and constants for the IBR128 block-cipher control slice.
//   state_t          : controller state encoding
//   DEFAULT_TIMEOUT  : default done-wait limit in cycles
//   CNT_W            : wait-counter width (covers TIMEOUT up to 65535)
// ---------------------------------------------------------------------------
package ibr128_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_KEY  = 3'd1,
        ST_HI   = 3'd2,
        ST_LO   = 3'd3,
        ST_DONE = 3'd4
    } state_t;

    localparam int DEFAULT_TIMEOUT = 1023;
    localparam int CNT_W           = 16;

endpackage

// File: rtl/ibr128_wait_cnt.sv
// ---------------------------------------------------------------------------
// ibr128_wait_cnt
// Clearable up-counter measuring how long the controller has waited for a
// done pulse in its current state.
//   Clk, RstN : clock, synchronous active-low reset
//   i_clr     : force count to zero (state entry)
//   i_en      : count this cycle
//   o_first   : count is zero, i.e. first cycle in the state
//   o_tc      : count has reached TIMEOUT
// ---------------------------------------------------------------------------
module ibr128_wait_cnt
    import ibr128_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic Clk,
    input  logic RstN,
    input  logic i_clr,
    input  logic i_en,
    output logic o_first,
    output logic o_tc
);

    localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT);

    logic [CNT_W-1:0] r_cnt;

    // Saturates at TIMEOUT; the controller always leaves the state there.
    always_ff @(posedge Clk) begin
        if (!RstN) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_en && !o_tc) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    assign o_first = (r_cnt == '0);
    assign o_tc    = (r_cnt == TC_VAL);

endmodule

// File: rtl/ibr128_core_ctrl.sv
// ---------------------------------------------------------------------------
// ibr128_core_ctrl
// Sequences one 128-bit block through a 64-bit cipher core as two halves,
// with an optional key-schedule refresh first and a per-state done timeout.
//   Clk, RstN            : clock, synchronous active-low reset
//   block_start/encrypt/pData/sa : request level, direction, data, key refresh
//   block_ready/eData/err: result handshake, result block, timeout flag
//   key_start/key_done   : key expansion start pulse / completion pulse
//   core_start/core_encrypt/core_din : core start pulse, direction, input half
//   core_done/core_dout  : core result pulse and half
//
// state | meaning
// IDLE  | waiting for a rising edge on block_start
// KEY   | key expansion running, waiting for key_done
// HI    | core processing pData[127:64]
// LO    | core processing pData[63:0]
// DONE  | result (or timeout) presented until block_start drops
// ---------------------------------------------------------------------------
module ibr128_core_ctrl
    import ibr128_pkg::*;
#(
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic         Clk,
    input  logic         RstN,
    input  logic         block_start,
    input  logic         encrypt,
    input  logic [127:0] pData,
    input  logic         sa,
    output logic         block_ready,
    output logic [127:0] eData,
    output logic         err,
    output logic         key_start,
    input  logic         key_done,
    output logic         core_start,
    output logic         core_encrypt,
    output logic [63:0]  core_din,
    input  logic         core_done,
    input  logic [63:0]  core_dout
);

    state_t         r_state;
    state_t         w_state_next;
    logic           r_bs_prev;
    logic           r_armed;
    logic [127:0]   r_pdata;
    logic           r_enc;
    logic [63:0]    r_shadow;
    logic [127:0]   r_edata;
    logic           r_err;
    logic           r_ready;

    logic w_accept;
    logic w_first;
    logic w_tc;
    logic w_wait;
    logic w_hi_ok;
    logic w_lo_ok;
    logic w_timeout;

    // A level already high when reset releases is not an edge: the request
    // path is armed only once block_start has been seen low.
    assign w_accept = (r_state == ST_IDLE) && r_armed && block_start && !r_bs_prev;
    assign w_wait   = (r_state == ST_KEY) || (r_state == ST_HI) || (r_state == ST_LO);

    ibr128_wait_cnt #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_cnt (
        .Clk     (Clk),
        .RstN    (RstN),
        .i_clr   (w_state_next != r_state),
        .i_en    (w_wait),
        .o_first (w_first),
        .o_tc    (w_tc)
    );

    // Abort beats done, done beats timeout; dones in the start cycle are ignored.
    always_comb begin
        w_state_next = r_state;
        w_hi_ok      = 1'b0;
        w_lo_ok      = 1'b0;
        w_timeout    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) w_state_next = sa ? ST_KEY : ST_HI;
            end
            ST_KEY: begin
                if (!block_start) begin
                    w_state_next = ST_IDLE;
                end else if (key_done && !w_first) begin
                    w_state_next = ST_HI;
                end else if (w_tc) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_HI: begin
                if (!block_start) begin
                    w_state_next = ST_IDLE;
                end else if (core_done && !w_first) begin
                    w_hi_ok      = 1'b1;
                    w_state_next = ST_LO;
                end else if (w_tc) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_LO: begin
                if (!block_start) begin
                    w_state_next = ST_IDLE;
                end else if (core_done && !w_first) begin
                    w_lo_ok      = 1'b1;
                    w_state_next = ST_DONE;
                end else if (w_tc) begin
                    w_timeout    = 1'b1;
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                if (!block_start) w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (!RstN) begin
            r_state   <= ST_IDLE;
            r_bs_prev <= 1'b0;
            r_armed   <= 1'b0;
            r_pdata   <= '0;
            r_enc     <= 1'b0;
            r_shadow  <= '0;
            r_edata   <= '0;
            r_err     <= 1'b0;
            r_ready   <= 1'b0;
        end else begin
            r_state   <= w_state_next;
            r_bs_prev <= block_start;
            if (!block_start) r_armed <= 1'b1;
            r_ready   <= (r_state == ST_DONE) && block_start;
            if (w_accept) begin
                r_pdata <= pData;
                r_enc   <= encrypt;
                r_err   <= 1'b0;
            end
            // Upper half is parked in a shadow so an abort in LO leaves eData intact.
            if (w_hi_ok) r_shadow <= core_dout;
            if (w_lo_ok) r_edata  <= {r_shadow, core_dout};
            if (w_timeout) begin
                r_edata <= '0;
                r_err   <= 1'b1;
            end
        end
    end

    assign key_start    = (r_state == ST_KEY) && w_first;
    assign core_start   = ((r_state == ST_HI) || (r_state == ST_LO)) && w_first;
    assign core_din     = (r_state == ST_LO) ? r_pdata[63:0] : r_pdata[127:64];
    assign core_encrypt = r_enc;
    assign eData        = r_edata;
    assign err          = r_err;
    assign block_ready  = r_ready;

endmodule
